// File: rtl/pool_2_maxpool_pkg.sv
// Shared geometry, FSM/phase encodings and window address helper for the layer-2 max-pool stage.
package pool_2_maxpool_pkg;

   localparam int DW         = 8;
   localparam int AW         = 7;
   localparam int IN_W       = 24;
   localparam int BANK_WORDS = 2 * IN_W;
   localparam int POOL_W     = IN_W / 2;
   localparam int CW         = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_e;

   // Order of the four reads inside a 2x2 window: top-left, top-right, bottom-left, bottom-right.
   typedef enum logic [1:0] {
      PH_TL = 2'd0,
      PH_TR = 2'd1,
      PH_BL = 2'd2,
      PH_BR = 2'd3
   } phase_e;

   function automatic logic [AW-1:0] win_addr(input logic bank, input logic [CW-1:0] win,
                                              input phase_e ph);
      logic [AW-1:0] a;
      a = bank ? AW'(BANK_WORDS) : '0;
      if (ph == PH_BL || ph == PH_BR) a = a + AW'(IN_W);
      a = a + AW'({win, 1'b0});
      if (ph == PH_TR || ph == PH_BR) a = a + AW'(1);
      return a;
   endfunction

endpackage

// File: rtl/pool_2_maxpool_if.sv
// Bank handshake, RAM read port and pooled-pixel stream of the max-pool stage.
interface pool_2_maxpool_if;
   import pool_2_maxpool_pkg::*;

   logic          bank_ready;
   logic          bank_sel;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          pool_valid;
   logic [DW-1:0] pool_data;
   logic [CW-1:0] pool_col;
   logic          pool_bank;
   logic          bank_done;
   logic          busy;
   logic          overrun;

   modport master (
      input  bank_ready, bank_sel, rd_data,
      output rd_en, rd_addr, pool_valid, pool_data, pool_col, pool_bank,
             bank_done, busy, overrun
   );

   modport slave (
      output bank_ready, bank_sel, rd_data,
      input  rd_en, rd_addr, pool_valid, pool_data, pool_col, pool_bank,
             bank_done, busy, overrun
   );

endinterface

// File: rtl/pool_2_maxpool_addr_gen.sv
// Window/phase/bank read sequencer: one RAM read per cycle, 48 per bank, back-to-back when restarted
// on the last read. No backpressure; start_i is only honoured when idle or on the last read.
module pool_2_maxpool_addr_gen
   import pool_2_maxpool_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          start_bank_i,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   output phase_e        ph_o,
   output logic [CW-1:0] col_o,
   output logic          bank_o,
   output logic          last_o,
   output logic          idle_o
);

   state_e        state_q;
   phase_e        ph_q;
   logic [CW-1:0] win_q;
   logic          bank_q;
   logic          last;

   assign last = (state_q == ST_READ) && (win_q == CW'(POOL_W - 1)) && (ph_q == PH_BR);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ph_q    <= PH_TL;
         win_q   <= '0;
         bank_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q <= ST_READ;
                  ph_q    <= PH_TL;
                  win_q   <= '0;
                  bank_q  <= start_bank_i;
               end
            end
            ST_READ: begin
               if (last) begin
                  ph_q  <= PH_TL;
                  win_q <= '0;
                  if (start_i) begin
                     bank_q <= start_bank_i;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  ph_q <= phase_e'(ph_q + 2'd1);
                  if (ph_q == PH_BR) win_q <= win_q + 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_en_o   = (state_q == ST_READ);
   assign rd_addr_o = rd_en_o ? win_addr(bank_q, win_q, ph_q) : '0;
   assign ph_o      = ph_q;
   assign col_o     = win_q;
   assign bank_o    = bank_q;
   assign last_o    = last;
   assign idle_o    = (state_q == ST_IDLE);

endmodule

// File: rtl/pool_2_maxpool.sv
// 2x2/stride-2 max-pool over ping-pong RAM banks: first pixel 6 cycles after bank_ready, one per 4 cycles.
// No downstream backpressure; one request can queue behind the active bank, further ones are dropped.
module pool_2_maxpool
   import pool_2_maxpool_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   pool_2_maxpool_if.master pool_if
);

   logic          start;
   logic          start_bank;
   logic          can_start;
   logic          ag_rd_en;
   logic [AW-1:0] ag_addr;
   phase_e        ag_ph;
   logic [CW-1:0] ag_col;
   logic          ag_bank;
   logic          ag_last;
   logic          ag_idle;

   logic          pending_q, pending_d;
   logic          pend_bank_q, pend_bank_d;

   logic          tag_vld_q;
   phase_e        tag_ph_q;
   logic [CW-1:0] tag_col_q;
   logic          tag_bank_q;
   logic          tag_last_q;
   logic [DW-1:0] acc_q;
   logic [DW-1:0] max_v;
   logic          win_end;

   logic          pool_valid_q;
   logic [DW-1:0] pool_data_q;
   logic [CW-1:0] pool_col_q;
   logic          pool_bank_q;
   logic          bank_done_q;

   // A queued bank always wins over a fresh request; a request arriving while one is queued is lost.
   always_comb begin
      can_start   = ag_idle | ag_last;
      start       = can_start & (pending_q | pool_if.bank_ready);
      start_bank  = pending_q ? pend_bank_q : pool_if.bank_sel;
      pending_d   = pending_q;
      pend_bank_d = pend_bank_q;
      if (start && pending_q) begin
         pending_d = 1'b0;
      end else if (!can_start && pool_if.bank_ready && !pending_q) begin
         pending_d   = 1'b1;
         pend_bank_d = pool_if.bank_sel;
      end
   end

   pool_2_maxpool_addr_gen u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .start_bank_i (start_bank),
      .rd_en_o      (ag_rd_en),
      .rd_addr_o    (ag_addr),
      .ph_o         (ag_ph),
      .col_o        (ag_col),
      .bank_o       (ag_bank),
      .last_o       (ag_last),
      .idle_o       (ag_idle)
   );

   assign max_v   = (pool_if.rd_data > acc_q) ? pool_if.rd_data : acc_q;
   assign win_end = tag_vld_q && (tag_ph_q == PH_BR);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q    <= 1'b0;
         pend_bank_q  <= 1'b0;
         tag_vld_q    <= 1'b0;
         tag_ph_q     <= PH_TL;
         tag_col_q    <= '0;
         tag_bank_q   <= 1'b0;
         tag_last_q   <= 1'b0;
         acc_q        <= '0;
         pool_valid_q <= 1'b0;
         pool_data_q  <= '0;
         pool_col_q   <= '0;
         pool_bank_q  <= 1'b0;
         bank_done_q  <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         pend_bank_q <= pend_bank_d;
         // Tags ride one cycle behind the read to line up with the registered RAM data.
         tag_vld_q   <= ag_rd_en;
         tag_ph_q    <= ag_ph;
         tag_col_q   <= ag_col;
         tag_bank_q  <= ag_bank;
         tag_last_q  <= ag_last;
         if (tag_vld_q) acc_q <= (tag_ph_q == PH_TL) ? pool_if.rd_data : max_v;
         pool_valid_q <= win_end;
         pool_data_q  <= win_end ? max_v : '0;
         pool_col_q   <= win_end ? tag_col_q : '0;
         pool_bank_q  <= win_end ? tag_bank_q : 1'b0;
         bank_done_q  <= win_end && tag_last_q;
      end
   end

   assign pool_if.rd_en      = ag_rd_en;
   assign pool_if.rd_addr    = ag_addr;
   assign pool_if.pool_valid = pool_valid_q;
   assign pool_if.pool_data  = pool_data_q;
   assign pool_if.pool_col   = pool_col_q;
   assign pool_if.pool_bank  = pool_bank_q;
   assign pool_if.bank_done  = bank_done_q;
   assign pool_if.busy       = ag_rd_en | tag_vld_q | pool_valid_q;
   // Combinational so the pulse lands in the same cycle as the dropped request.
   assign pool_if.overrun    = rst & pool_if.bank_ready & pending_q;

endmodule

// File: tb/tb_pool_2_maxpool.sv
// Directed bench for pool_2_maxpool: RAM model, event logger, vector table and corner sequences.
module tb_pool_2_maxpool;
   import pool_2_maxpool_pkg::*;

   logic clk;
   logic rst;
   pool_2_maxpool_if pif();

   pool_2_maxpool dut (
      .clk     (clk),
      .rst     (rst),
      .pool_if (pif)
   );

   logic [7:0] mem [0:95];
   int cyc = 0;
   int t0 = 0;
   int nvec = 0;
   int nbad = 0;

   typedef struct {
      int         c;
      logic [7:0] d;
      logic [3:0] col;
      logic       b;
   } pv_t;

   typedef struct {
      logic       bank;
      int         win;
      int         pos;
      logic [7:0] vmax;
      logic [7:0] voth;
      logic [7:0] exp_d;
      logic [3:0] exp_col;
      logic       exp_b;
      int         exp_cyc;
   } vec_t;

   pv_t pv_q[$];
   int  done_q[$];
   int  ovr_q[$];
   int  rdc_q[$];
   int  rda_q[$];
   int  busy_q[$];
   vec_t vt [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      pif.rd_data <= pif.rd_en ? mem[pif.rd_addr] : 8'd0;
   end

   always @(negedge clk) begin
      pv_t e;
      #2;
      if (pif.pool_valid) begin
         e.c = cyc; e.d = pif.pool_data; e.col = pif.pool_col; e.b = pif.pool_bank;
         pv_q.push_back(e);
      end
      if (pif.bank_done) done_q.push_back(cyc);
      if (pif.overrun) ovr_q.push_back(cyc);
      if (pif.busy) busy_q.push_back(cyc);
      if (pif.rd_en) begin
         rdc_q.push_back(cyc);
         rda_q.push_back(int'(pif.rd_addr));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {7'd0, pif.rd_en, pif.rd_addr, pif.pool_valid, pif.pool_data, pif.pool_col,
              pif.pool_bank, pif.bank_done, pif.busy, pif.overrun};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_logs();
      pv_q.delete(); done_q.delete(); ovr_q.delete();
      rdc_q.delete(); rda_q.delete(); busy_q.delete();
   endtask

   task automatic fire(input logic b);
      pif.bank_ready = 1'b1;
      pif.bank_sel   = b;
      tick();
      pif.bank_ready = 1'b0;
      pif.bank_sel   = 1'b0;
   endtask

   task automatic fill_ramp();
      for (int a = 0; a < 96; a++) mem[a] = 8'(a);
   endtask

   initial begin
      rst = 1'b0;
      pif.bank_ready = 1'b0;
      pif.bank_sel   = 1'b0;
      fill_ramp();

      vt[0] = '{1'b1,  5, 0, 8'd200, 8'd7,   8'd200, 4'd5,  1'b1, 26};
      vt[1] = '{1'b1,  5, 1, 8'd200, 8'd7,   8'd200, 4'd5,  1'b1, 26};
      vt[2] = '{1'b1,  5, 2, 8'd200, 8'd7,   8'd200, 4'd5,  1'b1, 26};
      vt[3] = '{1'b1,  5, 3, 8'd200, 8'd7,   8'd200, 4'd5,  1'b1, 26};
      vt[4] = '{1'b1,  9, 0, 8'd9,   8'd9,   8'd9,   4'd9,  1'b1, 42};
      vt[5] = '{1'b0,  0, 3, 8'd255, 8'd254, 8'd255, 4'd0,  1'b0, 6};
      vt[6] = '{1'b0, 11, 0, 8'd128, 8'd127, 8'd128, 4'd11, 1'b0, 50};
      vt[7] = '{1'b1, 11, 2, 8'd0,   8'd0,   8'd0,   4'd11, 1'b1, 50};

      // Reset held with requests toggling
      for (int i = 0; i < 3; i++) begin
         tick();
         pif.bank_ready = (i % 2 == 0);
         pif.bank_sel   = 1'b1;
         #2;
         check($sformatf("reset_outs[%0d]", i), outs(), 32'd0);
      end
      tick();
      pif.bank_ready = 1'b0;
      pif.bank_sel   = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("reset_no_reads", rdc_q.size(), 0);

      // Single bank 0, RAM holds its own address
      clear_logs();
      tick();
      t0 = cyc;
      fire(1'b0);
      repeat (60) tick();
      check("sb_nreads", rda_q.size(), 48);
      for (int k = 0; k < 48 && k < rda_q.size(); k++) begin
         check($sformatf("sb_addr[%0d]", k), rda_q[k],
               ((k % 4) >= 2 ? 24 : 0) + 2 * (k / 4) + (k % 2));
         check($sformatf("sb_rdcyc[%0d]", k), rdc_q[k] - t0, k + 1);
      end
      check("sb_npool", pv_q.size(), 12);
      for (int j = 0; j < 12 && j < pv_q.size(); j++) begin
         check($sformatf("sb_data[%0d]", j), pv_q[j].d, 25 + 2 * j);
         check($sformatf("sb_cyc[%0d]", j), pv_q[j].c - t0, 6 + 4 * j);
         check($sformatf("sb_col[%0d]", j), pv_q[j].col, j);
         check($sformatf("sb_bank[%0d]", j), pv_q[j].b, 0);
      end
      check("sb_ndone", done_q.size(), 1);
      if (done_q.size() > 0) check("sb_done_cyc", done_q[0] - t0, 50);
      check("sb_nbusy", busy_q.size(), 50);
      if (busy_q.size() > 0) begin
         check("sb_busy_first", busy_q[0] - t0, 1);
         check("sb_busy_last", busy_q[$] - t0, 50);
      end
      check("sb_novr", ovr_q.size(), 0);

      // Table: max position, equal values, unsigned extremes, phase-0 reload
      for (int i = 0; i < 8; i++) begin
         int base;
         pv_t e;
         for (int a = 0; a < 96; a++) mem[a] = 8'd1;
         base = vt[i].bank ? 48 : 0;
         for (int p = 0; p < 4; p++)
            mem[base + (p / 2) * 24 + 2 * vt[i].win + (p % 2)] = (p == vt[i].pos) ? vt[i].vmax : vt[i].voth;
         clear_logs();
         tick();
         t0 = cyc;
         fire(vt[i].bank);
         repeat (60) tick();
         check($sformatf("vec%0d_npool", i), pv_q.size(), 12);
         if (pv_q.size() == 12) begin
            e = pv_q[vt[i].win];
            check($sformatf("vec%0d_data", i), e.d, vt[i].exp_d);
            check($sformatf("vec%0d_col", i), e.col, vt[i].exp_col);
            check($sformatf("vec%0d_bank", i), e.b, vt[i].exp_b);
            check($sformatf("vec%0d_cyc", i), e.c - t0, vt[i].exp_cyc);
         end
      end

      // Back-to-back: second request on the 48th read
      fill_ramp();
      clear_logs();
      tick();
      t0 = cyc;
      fire(1'b0);
      repeat (47) tick();
      fire(1'b1);
      repeat (60) tick();
      check("b2b_nreads", rda_q.size(), 96);
      if (rda_q.size() == 96) begin
         check("b2b_addr48", rda_q[48], 48);
         check("b2b_cyc48", rdc_q[48] - t0, 49);
      end
      check("b2b_ndone", done_q.size(), 2);
      if (done_q.size() == 2) begin
         check("b2b_done0", done_q[0] - t0, 50);
         check("b2b_done1", done_q[1] - t0, 98);
      end
      check("b2b_npool", pv_q.size(), 24);
      if (pv_q.size() == 24) begin
         check("b2b_w0b1_data", pv_q[12].d, 73);
         check("b2b_w0b1_bank", pv_q[12].b, 1);
         check("b2b_w0b1_cyc", pv_q[12].c - t0, 54);
         check("b2b_w11b1_data", pv_q[23].d, 95);
      end
      check("b2b_nbusy", busy_q.size(), 98);
      check("b2b_novr", ovr_q.size(), 0);

      // Overrun: third request while one is already queued
      clear_logs();
      tick();
      t0 = cyc;
      fire(1'b0);
      repeat (9) tick();
      fire(1'b1);
      repeat (9) tick();
      fire(1'b0);
      repeat (100) tick();
      check("ovr_count", ovr_q.size(), 1);
      if (ovr_q.size() > 0) check("ovr_cyc", ovr_q[0] - t0, 20);
      check("ovr_ndone", done_q.size(), 2);
      if (done_q.size() == 2) check("ovr_done1", done_q[1] - t0, 98);
      check("ovr_nreads", rda_q.size(), 96);
      check("ovr_npool", pv_q.size(), 24);
      if (pv_q.size() == 24) check("ovr_second_bank", pv_q[12].b, 1);

      // Reset in the middle of a bank, then restart
      clear_logs();
      tick();
      t0 = cyc;
      fire(1'b0);
      repeat (19) tick();
      rst = 1'b0;
      tick();
      #1;
      check("mid_rst_outs", outs(), 32'd0);
      rst = 1'b1;
      repeat (60) tick();
      check("mid_rst_ndone", done_q.size(), 0);
      check("mid_rst_npool", pv_q.size(), 4);
      clear_logs();
      tick();
      t0 = cyc;
      fire(1'b0);
      repeat (60) tick();
      check("restart_npool", pv_q.size(), 12);
      if (pv_q.size() > 0) begin
         check("restart_first_data", pv_q[0].d, 25);
         check("restart_first_col", pv_q[0].col, 0);
         check("restart_first_cyc", pv_q[0].c - t0, 6);
      end
      check("restart_ndone", done_q.size(), 1);
      if (done_q.size() > 0) check("restart_done_cyc", done_q[0] - t0, 50);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
